// File: rtl/serial_pkg.sv
// Shared types and constants for the serial add/subtract unit.
// Provides the FSM state encoding, the hex-to-segment table and the digit-count helper.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic int ndig(input int width);
    return (width + 1 + 3) / 4;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment decoder.
module hex7seg
  import serial_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial WIDTH-bit adder/subtractor with busy/done handshake and signed overflow.
// Optional seven-segment readout of the result when SERIAL_ADDSUB_SEG_EN is defined.
//
// state | meaning
// IDLE  | waiting for go; operands captured on the edge that sees go=1
// SHIFT | one result bit per clock, LSB first, for WIDTH clocks
// DONE  | result registered, done pulses for this one cycle
module serial_addsub_unit
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             go,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
`ifdef SERIAL_ADDSUB_SEG_EN
  output logic [7*ndig(WIDTH)-1:0] HEX,
`endif
  output logic             ovf
);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             c_next;

  assign s_bit  = ra[0] ^ rb[0] ^ carry;
  assign c_next = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            ra    <= A;
            rb    <= sub ? ~B : B;
            carry <= sub;  // +1 of the two's complement for subtraction
            acc   <= '0;
            cnt   <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          ra    <= ra >> 1;
          rb    <= rb >> 1;
          acc   <= {s_bit, acc[WIDTH-1:1]};
          carry <= c_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // carry still holds the carry into the MSB on this last step
            sum   <= {c_next, s_bit, acc[WIDTH-1:1]};
            ovf   <= carry ^ c_next;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_SEG_EN
  localparam int NDIG = ndig(WIDTH);

  logic [4*NDIG-1:0] sum_pad;
  assign sum_pad = (4*NDIG)'(sum);

  for (genvar d = 0; d < NDIG; d++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble (sum_pad[4*d +: 4]),
      .seg    (HEX[7*d +: 7])
    );
  end
`endif

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit: WIDTH=8 and WIDTH=4 instances with a result scoreboard.
module tb_serial_addsub_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a8 = '0, b8 = '0;
  logic       sub8 = 1'b0, go8 = 1'b0;
  logic       busy8, done8, ovf8;
  logic [8:0] sum8;
  logic [3:0] a4 = '0, b4 = '0;
  logic       sub4 = 1'b0, go4 = 1'b0;
  logic       busy4, done4, ovf4;
  logic [4:0] sum4;
`ifdef SERIAL_ADDSUB_SEG_EN
  logic [20:0] hex8;
  logic [13:0] hex4;
`endif

  serial_addsub_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .sub(sub8), .go(go8),
    .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADDSUB_SEG_EN
    .HEX(hex8),
`endif
    .ovf(ovf8));

  serial_addsub_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .sub(sub4), .go(go4),
    .busy(busy4), .done(done4), .sum(sum4),
`ifdef SERIAL_ADDSUB_SEG_EN
    .HEX(hex4),
`endif
    .ovf(ovf4));

  int tests = 0;
  int fails = 0;
  logic [9:0] sb8[$];
  logic [5:0] sb4[$];

  typedef struct {logic [7:0] a, b; logic s; logic [8:0] es; logic eo;} vec8_t;
  typedef struct {logic [3:0] a, b; logic s; logic [4:0] es; logic eo;} vec4_t;
  vec8_t v8[9];
  vec4_t v4[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [8:0] r;
    logic       o;
    if (!s) begin
      r = {1'b0, a} + {1'b0, b};
      o = (a[7] == b[7]) && (r[7] != a[7]);
    end else begin
      r = {1'b0, a} + 9'd256 - {1'b0, b};
      o = (a[7] != b[7]) && (r[7] != a[7]);
    end
    return {r, o};
  endfunction

  always @(negedge clk) begin
    if (rst && done8) begin
      if (sb8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
        logic [9:0] e;
        e = sb8.pop_front();
        chk("sum8", sum8, e[9:1]);
        chk("ovf8", ovf8, e[0]);
      end
    end
    if (rst && done4) begin
      if (sb4.size() == 0) chk("unexpected_done4", 1, 0);
      else begin
        logic [5:0] e;
        e = sb4.pop_front();
        chk("sum4", sum4, e[5:1]);
        chk("ovf4", ovf4, e[0]);
      end
    end
  end

  // Returns number of posedges until done is seen at a negedge; -1 on timeout.
  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!done8 && n < 40);
    if (!done8) begin
      chk("timeout8", 0, 1);
      n = -1;
    end
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    do begin
      @(posedge clk); n++;
      @(negedge clk);
    end while (!done4 && n < 40);
    if (!done4) begin
      chk("timeout4", 0, 1);
      n = -1;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [8:0] es, input logic eo);
    int n;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; go8 = 1'b1;
    sb8.push_back({es, eo});
    @(posedge clk); #1;
    go8 = 1'b0; a8 = ~a; b8 = ~b; sub8 = ~s;
    chk("busy8_after_go", busy8, 1);
    wait_done8(n);
    chk("latency8", n, 8);
    @(negedge clk);
    chk("done8_one_cycle", done8, 0);
    chk("busy8_idle", busy8, 0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                      input logic [4:0] es, input logic eo);
    int n;
    @(negedge clk);
    a4 = a; b4 = b; sub4 = s; go4 = 1'b1;
    sb4.push_back({es, eo});
    @(posedge clk); #1;
    go4 = 1'b0;
    chk("busy4_after_go", busy4, 1);
    wait_done4(n);
    chk("latency4", n, 4);
    @(negedge clk);
    chk("done4_one_cycle", done4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    v8[0] = '{8'd200, 8'd100, 1'b0, 9'h12C, 1'b0};
    v8[1] = '{8'd100, 8'd200, 1'b1, 9'h09C, 1'b1};
    v8[2] = '{8'd5,   8'd5,   1'b1, 9'h100, 1'b0};
    v8[3] = '{8'd127, 8'd1,   1'b0, 9'h080, 1'b1};
    v8[4] = '{8'd128, 8'd128, 1'b0, 9'h100, 1'b1};
    v8[5] = '{8'd0,   8'd1,   1'b1, 9'h0FF, 1'b0};
    v8[6] = '{8'd128, 8'd1,   1'b1, 9'h17F, 1'b1};
    v8[7] = '{8'd255, 8'd255, 1'b0, 9'h1FE, 1'b0};
    v8[8] = '{8'd0,   8'd0,   1'b0, 9'h000, 1'b0};
    v4[0] = '{4'd15, 4'd1, 1'b0, 5'h10, 1'b0};
    v4[1] = '{4'd7,  4'd1, 1'b0, 5'h08, 1'b1};
    v4[2] = '{4'd3,  4'd5, 1'b1, 5'h0E, 1'b0};
    v4[3] = '{4'd8,  4'd1, 1'b1, 5'h17, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_done8", done8, 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_without_go", busy8, 0);

    for (int i = 0; i < 9; i++) begin
      run8(v8[i].a, v8[i].b, v8[i].s, v8[i].es, v8[i].eo);
`ifdef SERIAL_ADDSUB_SEG_EN
      if (i == 0) begin
        chk("hex_d0", hex8[6:0], 7'b1000110);
        chk("hex_d1", hex8[13:7], 7'b0100100);
        chk("hex_d2", hex8[20:14], 7'b1111001);
      end
`endif
    end

    for (int i = 0; i < 6; i++) begin
      logic [7:0] ra, rb;
      logic       rs;
      logic [9:0] m;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      m  = model8(ra, rb, rs);
      run8(ra, rb, rs, m[9:1], m[0]);
    end

    for (int i = 0; i < 4; i++)
      run4(v4[i].a, v4[i].b, v4[i].s, v4[i].es, v4[i].eo);

    // go while busy is ignored; go held high restarts after DONE
    @(negedge clk);
    a8 = 8'd1; b8 = 8'd1; sub8 = 1'b0; go8 = 1'b1;
    sb8.push_back({9'h002, 1'b0});
    @(posedge clk); #1 go8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd255; go8 = 1'b1;
    sb8.push_back({9'h1FE, 1'b0});
    wait_done8(n);
    chk("latency_ignored_go", n, 6);
    @(negedge clk);
    chk("busy_gap_low", busy8, 0);
    @(negedge clk);
    chk("busy_restart_high", busy8, 1);
    go8 = 1'b0;
    wait_done8(n);
    chk("latency_restart", n, 8);
    @(negedge clk);

    // leave ovf set, then abort mid-operation with reset
    run8(8'd127, 8'd1, 1'b0, 9'h080, 1'b1);
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; sub8 = 1'b0; go8 = 1'b1;
    @(posedge clk); #1 go8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("busy_before_abort", busy8, 1);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_ovf", ovf8, 0);
`ifdef SERIAL_ADDSUB_SEG_EN
    chk("abort_hex", hex8, {3{7'b1000000}});
`endif
    @(negedge clk) rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", busy8, 0);
    chk("post_reset_sum", sum8, 0);
    run8(8'd10, 8'd3, 1'b1, 9'h107, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb8_drained", sb8.size(), 0);
    chk("sb4_drained", sb4.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
